traffic_conflict_monitor: RTL and testbench

- Independent safety monitor on the 36 lamp drives of the four-road intersection controller (4 roads x {L,S,R} x {red,yellow,green}).
- Decodes the displayed phase and checks lamp integrity, group consistency, conflicting greens, illegal sequencing and timing minima/maxima.
- Latches the first fault; the top level uses `fault` to force all-red flash.
- Same clock as the controller. The lamp inputs are registered controller outputs.

---
 rtl/traffic_conflict_monitor.sv | 116 +++++++++++
 tb/tb_traffic_conflict_monitor.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor: independent lamp-drive safety monitor; latches the first conflict/sequencing/timing fault
module traffic_conflict_monitor #(
  parameter int MIN_YELLOW = 5,
  parameter int MIN_CLEAR  = 5,
  parameter int MAX_GREEN  = 60,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] lamp_red,
  input  logic [11:0] lamp_yellow,
  input  logic [11:0] lamp_green,
  input  logic        clear_fault,
  output logic [2:0]  phase,
  output logic        phase_yellow,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [3:0]  fault_index,
  output logic [15:0] cycles_done
);
  localparam logic [1:0] RED = 2'd0, GRN = 2'd1, YEL = 2'd2;
  localparam logic [3:0][11:0] GM = {12'h900, 12'h618, 12'h024, 12'h0c3};
  localparam logic [3:0][3:0] LEAD = {4'd8, 4'd3, 4'd2, 4'd0};
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] MY = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] MC = CNT_W'(MIN_CLEAR);
  localparam logic [CNT_W-1:0] MG = CNT_W'(MAX_GREEN);
  logic [1:0] gs [4];
  logic [1:0] cur [4];
  logic [1:0] gs_n [4];
  logic [CNT_W-1:0] ycnt [4];
  logic [CNT_W-1:0] gcnt [4];
  logic [CNT_W-1:0] clrcnt;
  logic [11:0] one;
  logic [3:0] mism, bad, nonred, c4, c5, c6, c7;
  logic [2:0] code, nr_cnt, ph_n;
  logic [3:0] idx;
  logic [1:0] hi;
  logic all_red, all_red_n, py_n, d_done;
  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    return v == CMAX ? v : v + 1'b1;
  endfunction
  assign one = (lamp_red ^ lamp_yellow ^ lamp_green) & ~(lamp_red & lamp_yellow & lamp_green);
  always_comb begin
    code = '0;
    idx = '0;
    nr_cnt = '0;
    hi = '0;
    all_red = 1'b1;
    all_red_n = 1'b1;
    for (int g = 0; g < 4; g++) begin
      mism[g] = |(GM[g] & (({12{lamp_red[LEAD[g]]}} ^ lamp_red) |
                           ({12{lamp_yellow[LEAD[g]]}} ^ lamp_yellow) |
                           ({12{lamp_green[LEAD[g]]}} ^ lamp_green)));
      bad[g] = mism[g] | (|(GM[g] & ~one));
      cur[g] = lamp_green[LEAD[g]] ? GRN : lamp_yellow[LEAD[g]] ? YEL : RED;
      nonred[g] = |(GM[g] & (lamp_yellow | lamp_green));
      gs_n[g] = bad[g] ? gs[g] : cur[g];
      c4[g] = !bad[g] && ((gs[g] == GRN && cur[g] == RED) || (gs[g] == YEL && cur[g] == GRN) ||
                          (gs[g] == RED && cur[g] == YEL));
      c5[g] = !bad[g] && gs[g] == YEL && cur[g] == RED && ycnt[g] < MY;
      c6[g] = !bad[g] && gs[g] == RED && cur[g] == GRN && clrcnt < MC;
      c7[g] = !bad[g] && gs[g] == GRN && cur[g] == GRN && gcnt[g] >= MG;
      nr_cnt = nr_cnt + {2'b0, nonred[g]};
      hi = nonred[g] ? 2'(g) : hi;
      all_red &= gs[g] == RED;
      all_red_n &= gs_n[g] == RED;
    end
    // later assignments win: highest code and index first, lowest last
    for (int g = 3; g >= 0; g--) if (c7[g]) begin code = 3'd7; idx = 4'(g); end
    for (int g = 3; g >= 0; g--) if (c6[g]) begin code = 3'd6; idx = 4'(g); end
    for (int g = 3; g >= 0; g--) if (c5[g]) begin code = 3'd5; idx = 4'(g); end
    for (int g = 3; g >= 0; g--) if (c4[g]) begin code = 3'd4; idx = 4'(g); end
    if (nr_cnt > 3'd1) begin code = 3'd3; idx = {2'b0, hi}; end
    for (int g = 3; g >= 0; g--) if (mism[g]) begin code = 3'd2; idx = 4'(g); end
    for (int m = 11; m >= 0; m--) if (!one[m]) begin code = 3'd1; idx = 4'(m); end
    ph_n = (|bad || nr_cnt > 3'd1) ? 3'd7 : nr_cnt == 3'd0 ? 3'd0 : {1'b0, hi} + 3'd1;
    py_n = !(|bad) && nr_cnt == 3'd1 && cur[hi] == YEL;
    d_done = !bad[3] && gs[3] == YEL && cur[3] == RED;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int g = 0; g < 4; g++) begin
        gs[g] <= RED;
        ycnt[g] <= '0;
        gcnt[g] <= '0;
      end
      clrcnt <= MC;
      phase <= '0;
      phase_yellow <= 1'b0;
      fault <= 1'b0;
      fault_code <= '0;
      fault_index <= '0;
      cycles_done <= '0;
    end else begin
      for (int g = 0; g < 4; g++) begin
        gs[g] <= gs_n[g];
        ycnt[g] <= gs_n[g] != YEL ? ycnt[g] : gs[g] == YEL ? inc(ycnt[g]) : CNT_W'(1);
        gcnt[g] <= gs_n[g] != GRN ? gcnt[g] : gs[g] == GRN ? inc(gcnt[g]) : CNT_W'(1);
      end
      clrcnt <= !all_red_n ? '0 : all_red ? inc(clrcnt) : CNT_W'(1);
      phase <= ph_n;
      phase_yellow <= py_n;
      cycles_done <= cycles_done + 16'(d_done);
      if (code != 3'd0 && (!fault || clear_fault)) begin
        fault <= 1'b1;
        fault_code <= code;
        fault_index <= idx;
      end else if (clear_fault) begin
        fault <= 1'b0;
        fault_code <= '0;
        fault_index <= '0;
      end
    end
  end
endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// tb_traffic_conflict_monitor: vector table, directed corner sequences and a randomized run against a reference model
module tb_traffic_conflict_monitor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [11:0] lamp_red = '1, lamp_yellow = '0, lamp_green = '0;
  logic clear_fault = 1'b0;
  logic [2:0] phase;
  logic phase_yellow, fault;
  logic [2:0] fault_code;
  logic [3:0] fault_index;
  logic [15:0] cycles_done;
  int total = 0, passed = 0;
  int gof[12] = '{0, 0, 1, 2, 2, 1, 0, 0, 3, 2, 2, 3};
  int m_st[4], m_y[4], m_g[4];
  int m_clr, m_f, m_c, m_i, m_cyc, m_ph, m_py;

  traffic_conflict_monitor dut (
    .clk(clk), .reset(reset), .lamp_red(lamp_red), .lamp_yellow(lamp_yellow),
    .lamp_green(lamp_green), .clear_fault(clear_fault), .phase(phase),
    .phase_yellow(phase_yellow), .fault(fault), .fault_code(fault_code),
    .fault_index(fault_index), .cycles_done(cycles_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [35:0] l;
    logic clr;
    logic [2:0] ph;
    logic py, f;
    logic [2:0] c;
    logic [3:0] i;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // group state per group: 0 red, 1 green, 2 yellow; returns {red, yellow, green}
  function automatic logic [35:0] lamps(input int a, input int b, input int c, input int d);
    int st[4] = '{a, b, c, d};
    logic [11:0] r, y, g;
    for (int m = 0; m < 12; m++) begin
      r[m] = st[gof[m]] == 0;
      g[m] = st[gof[m]] == 1;
      y[m] = st[gof[m]] == 2;
    end
    return {r, y, g};
  endfunction

  function automatic logic [35:0] grp(input int g, input int s);
    return lamps(g == 0 ? s : 0, g == 1 ? s : 0, g == 2 ? s : 0, g == 3 ? s : 0);
  endfunction

  task automatic model_reset();
    for (int g = 0; g < 4; g++) begin m_st[g] = 0; m_y[g] = 0; m_g[g] = 0; end
    m_clr = 5; m_f = 0; m_c = 0; m_i = 0; m_cyc = 0; m_ph = 0; m_py = 0;
  endtask

  // best candidate kept as code*16+index so the smallest value is the winning fault
  task automatic model_step();
    int best = 1000;
    bit bad[4] = '{0, 0, 0, 0};
    bit nr[4] = '{0, 0, 0, 0};
    int cur[4], nst[4];
    int ld[4] = '{0, 2, 3, 8};
    int cnt = 0, hi = 0;
    bit pre_ar = 1, ar = 1, anyb;
    for (int m = 0; m < 12; m++) begin
      int g = gof[m];
      int s = int'(lamp_red[m]) + int'(lamp_yellow[m]) + int'(lamp_green[m]);
      if (s != 1) begin bad[g] = 1; if (16 + m < best) best = 16 + m; end
      if ({lamp_red[m], lamp_yellow[m], lamp_green[m]} !=
          {lamp_red[ld[g]], lamp_yellow[ld[g]], lamp_green[ld[g]]}) begin
        bad[g] = 1;
        if (32 + g < best) best = 32 + g;
      end
      if (lamp_yellow[m] || lamp_green[m]) nr[g] = 1;
    end
    for (int g = 0; g < 4; g++) begin
      cur[g] = lamp_green[ld[g]] ? 1 : lamp_yellow[ld[g]] ? 2 : 0;
      if (nr[g]) begin cnt++; hi = g; end
    end
    if (cnt > 1 && 48 + hi < best) best = 48 + hi;
    for (int g = 0; g < 4; g++) if (!bad[g]) begin
      int p = m_st[g], c = cur[g];
      if (((p == 1 && c == 0) || (p == 2 && c == 1) || (p == 0 && c == 2)) && 64 + g < best) best = 64 + g;
      if (p == 2 && c == 0 && m_y[g] < 5 && 80 + g < best) best = 80 + g;
      if (p == 0 && c == 1 && m_clr < 5 && 96 + g < best) best = 96 + g;
      if (p == 1 && c == 1 && m_g[g] >= 60 && 112 + g < best) best = 112 + g;
    end
    anyb = bad[0] | bad[1] | bad[2] | bad[3];
    if (anyb || cnt > 1) begin m_ph = 7; m_py = 0; end
    else if (cnt == 0) begin m_ph = 0; m_py = 0; end
    else begin m_ph = hi + 1; m_py = cur[hi] == 2; end
    if (!bad[3] && m_st[3] == 2 && cur[3] == 0) m_cyc = (m_cyc + 1) % 65536;
    if (best < 1000 && (m_f == 0 || clear_fault)) begin m_f = 1; m_c = best / 16; m_i = best % 16; end
    else if (best == 1000 && clear_fault) begin m_f = 0; m_c = 0; m_i = 0; end
    for (int g = 0; g < 4; g++) begin
      pre_ar &= m_st[g] == 0;
      nst[g] = bad[g] ? m_st[g] : cur[g];
      ar &= nst[g] == 0;
      if (nst[g] == 2) m_y[g] = (m_st[g] == 2) ? ((m_y[g] < 255) ? m_y[g] + 1 : 255) : 1;
      if (nst[g] == 1) m_g[g] = (m_st[g] == 1) ? ((m_g[g] < 255) ? m_g[g] + 1 : 255) : 1;
    end
    m_clr = !ar ? 0 : pre_ar ? ((m_clr < 255) ? m_clr + 1 : 255) : 1;
    for (int g = 0; g < 4; g++) m_st[g] = nst[g];
  endtask

  task automatic tick();
    if (reset) model_reset();
    else model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [35:0] l);
    {lamp_red, lamp_yellow, lamp_green} = l;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_fault = 1'b0;
    drive(lamps(0, 0, 0, 0));
    tick();
    reset = 1'b0;
  endtask

  initial begin
    vec_t tv[11];
    int st[4];
    logic [35:0] lv;
    tv[0]  = '{lamps(0, 0, 0, 0), 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 4'd0};
    tv[1]  = '{lamps(1, 0, 0, 0), 1'b0, 3'd1, 1'b0, 1'b0, 3'd0, 4'd0};
    tv[2]  = '{lamps(2, 0, 0, 0), 1'b0, 3'd1, 1'b1, 1'b0, 3'd0, 4'd0};
    tv[3]  = '{lamps(0, 0, 0, 0), 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 4'd0};
    tv[4]  = '{lamps(0, 0, 0, 0), 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 4'd0};
    tv[5]  = '{lamps(0, 0, 0, 0) & ~(36'd1 << 28), 1'b0, 3'd7, 1'b0, 1'b1, 3'd1, 4'd4};
    tv[6]  = '{lamps(0, 0, 0, 0), 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 4'd4};
    tv[7]  = '{lamps(1, 1, 0, 0), 1'b0, 3'd7, 1'b0, 1'b1, 3'd1, 4'd4};
    tv[8]  = '{lamps(1, 1, 0, 0), 1'b1, 3'd7, 1'b0, 1'b1, 3'd3, 4'd1};
    tv[9]  = '{lamps(0, 0, 0, 0), 1'b1, 3'd0, 1'b0, 1'b1, 3'd4, 4'd0};
    tv[10] = '{lamps(0, 0, 0, 0), 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 4'd0};
    model_reset();
    tick();
    check("reset state", {phase, phase_yellow, fault, fault_code, fault_index, cycles_done}, 64'd0);
    reset = 1'b0;
    for (int k = 0; k < 11; k++) begin
      drive(tv[k].l);
      clear_fault = tv[k].clr;
      tick();
      check($sformatf("vector %0d {phase,py,fault,code,idx}", k),
            {phase, phase_yellow, fault, fault_code, fault_index},
            {tv[k].ph, tv[k].py, tv[k].f, tv[k].c, tv[k].i});
    end
    clear_fault = 1'b0;
    do_reset();
    for (int n = 0; n < 3; n++)
      for (int g = 0; g < 4; g++) begin
        drive(grp(g, 1));
        for (int k = 0; k < 30; k++) begin
          tick();
          check("nominal green", {phase, phase_yellow, fault}, {3'(g + 1), 1'b0, 1'b0});
        end
        drive(grp(g, 2));
        for (int k = 0; k < 5; k++) begin
          tick();
          check("nominal yellow", {phase, phase_yellow, fault}, {3'(g + 1), 1'b1, 1'b0});
        end
        drive(lamps(0, 0, 0, 0));
        for (int k = 0; k < 5; k++) begin
          tick();
          check("nominal red", {phase, phase_yellow, fault}, {3'd0, 1'b0, 1'b0});
        end
      end
    check("nominal cycles_done", cycles_done, 16'd3);
    do_reset();
    drive(lamps(1, 1, 0, 0));
    tick();
    check("conflict A+B", {fault, fault_code, fault_index}, {1'b1, 3'd3, 4'd1});
    do_reset();
    drive(grp(2, 1));
    tick();
    check("phase C", {phase, fault}, {3'd3, 1'b0});
    lamp_red[4] = 1'b1;
    tick();
    check("m4 red+green", {fault, fault_code, fault_index}, {1'b1, 3'd1, 4'd4});
    do_reset();
    drive(grp(1, 1));
    repeat (10) tick();
    drive(grp(1, 2));
    repeat (3) tick();
    check("B yellow no fault", fault, 1'b0);
    drive(lamps(0, 0, 0, 0));
    tick();
    check("short yellow", {fault, fault_code, fault_index}, {1'b1, 3'd5, 4'd1});
    do_reset();
    drive(grp(0, 1));
    repeat (10) tick();
    drive(grp(0, 2));
    repeat (5) tick();
    drive(lamps(0, 0, 0, 0));
    repeat (4) tick();
    check("short clear pre", fault, 1'b0);
    drive(grp(2, 1));
    tick();
    check("short clearance", {fault, fault_code, fault_index}, {1'b1, 3'd6, 4'd2});
    repeat (9) tick();
    drive(grp(2, 2));
    repeat (5) tick();
    drive(lamps(0, 0, 0, 0));
    tick();
    check("fault held", {fault, fault_code}, {1'b1, 3'd6});
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    check("clear_fault", {fault, fault_code, fault_index}, {1'b0, 3'd0, 4'd0});
    do_reset();
    drive(grp(3, 1));
    repeat (60) tick();
    check("D green 60", fault, 1'b0);
    tick();
    check("green timeout", {fault, fault_code, fault_index}, {1'b1, 3'd7, 4'd3});
    reset = 1'b1;
    #1;
    check("async reset", {phase, phase_yellow, fault, fault_code, fault_index, cycles_done}, 64'd0);
    model_reset();
    drive(grp(0, 1));
    reset = 1'b0;
    tick();
    check("A green after reset", {phase, fault}, {3'd1, 1'b0});
    do_reset();
    for (int g = 0; g < 4; g++) st[g] = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        int g = $urandom_range(0, 3);
        if ($urandom_range(0, 1) == 0) for (int j = 0; j < 4; j++) st[j] = 0;
        st[g] = $urandom_range(0, 2);
      end
      lv = lamps(st[0], st[1], st[2], st[3]);
      if ($urandom_range(0, 39) == 0) lv = lv ^ (36'd1 << $urandom_range(0, 35));
      drive(lv);
      clear_fault = $urandom_range(0, 15) == 0;
      tick();
      check("random vs model", {phase, phase_yellow, fault, fault_code, fault_index, cycles_done},
            {3'(m_ph), 1'(m_py), 1'(m_f), 3'(m_c), 4'(m_i), 16'(m_cyc)});
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
